// File: rtl/spi_wb_regs_pkg.sv
// Shared constants for the SPI Wishbone register block: sizes, word map,
// CTRL bit positions and a byte-lane helper.
package spi_wb_regs_pkg;

  localparam int SPI_MAX_CHAR      = 128;
  localparam int SPI_CHAR_LEN_BITS = 7;
  localparam int SPI_DIVIDER_LEN   = 16;
  localparam int SPI_SS_NB         = 8;

  // Word offsets, decoded from wb_adr_i[4:2]
  typedef enum logic [2:0] {
    SPI_RX_0     = 3'd0,
    SPI_RX_1     = 3'd1,
    SPI_RX_2     = 3'd2,
    SPI_RX_3     = 3'd3,
    SPI_CTRL     = 3'd4,
    SPI_DIVIDE   = 3'd5,
    SPI_SS       = 3'd6,
    SPI_UNMAPPED = 3'd7
  } spi_word_e;

  // CTRL register bit positions; bits above SPI_CTRL_ASS are not stored
  localparam int SPI_CTRL_GO         = 8;
  localparam int SPI_CTRL_RX_NEGEDGE = 9;
  localparam int SPI_CTRL_TX_NEGEDGE = 10;
  localparam int SPI_CTRL_LSB        = 11;
  localparam int SPI_CTRL_IE         = 12;
  localparam int SPI_CTRL_ASS        = 13;
  localparam int SPI_CTRL_W          = 14;

  // Expand the four Wishbone byte selects into a 32-bit bit mask
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/spi_wb_regs.sv
// Wishbone slave register file feeding the SPI shift register: TX load
// strobes, CTRL/DIVIDER/SS registers, RX readback and the end-of-transfer
// interrupt.
module spi_wb_regs
  import spi_wb_regs_pkg::*;
#(
  parameter int MAX_CHAR      = SPI_MAX_CHAR,
  parameter int CHAR_LEN_BITS = SPI_CHAR_LEN_BITS,
  parameter int DIV_WIDTH     = SPI_DIVIDER_LEN,
  parameter int SS_NB         = SPI_SS_NB
) (
  input  logic                     wb_clk_in,
  input  logic                     wb_rst_n,
  input  logic [4:0]               wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_int_o,
  input  logic                     tip,
  input  logic                     last,
  input  logic                     cpol_0,
  input  logic [MAX_CHAR-1:0]      p_out,
  output logic [31:0]              p_in,
  output logic [3:0]               byte_sel,
  output logic [3:0]               latch,
  output logic [CHAR_LEN_BITS-1:0] len,
  output logic                     go,
  output logic                     rx_negedge,
  output logic                     tx_negedge,
  output logic                     lsb,
  output logic [DIV_WIDTH-1:0]     divider,
  output logic [SS_NB-1:0]         ss_pad_o
);

  // RX readback works on a view at least four words wide so short shift
  // registers read as zero in the upper words.
  localparam int RX_W = (MAX_CHAR > 128) ? MAX_CHAR : 128;

  // Writable CTRL bits: char_len field plus go/rx_negedge/tx_negedge/lsb/ie/ass
  localparam logic [SPI_CTRL_W-1:0] CTRL_WMASK =
    SPI_CTRL_W'(14'h3F00 | ((1 << CHAR_LEN_BITS) - 1));

  spi_word_e               word;
  logic                    access;
  logic                    wr_ok;
  logic                    xfer_end;
  logic [31:0]             lanes;
  logic [SPI_CTRL_W-1:0]   ctrl;
  logic [SPI_CTRL_W-1:0]   ctrl_m;
  logic [SS_NB-1:0]        ss;
  logic [RX_W-1:0]         rx_view;
  logic [31:0]             rd_data;
  logic                    unused_bits;

  assign word     = spi_word_e'(wb_adr_i[4:2]);
  assign access   = wb_stb_i & wb_cyc_i & ~wb_ack_o & ~wb_err_o;
  // Register and TX writes are locked out while a transfer is running
  assign wr_ok    = access & wb_we_i & ~tip;
  assign xfer_end = tip & last & cpol_0;
  assign lanes    = lane_mask(wb_sel_i);
  assign ctrl_m   = lanes[SPI_CTRL_W-1:0] & CTRL_WMASK;
  assign rx_view  = RX_W'(p_out);

  assign unused_bits = ^{wb_adr_i[1:0], lanes[31:16]};

  // Parallel load interface passes the bus data and lanes straight through
  assign p_in     = wb_dat_i;
  assign byte_sel = wb_sel_i;

  assign len        = ctrl[CHAR_LEN_BITS-1:0];
  assign go         = ctrl[SPI_CTRL_GO];
  assign rx_negedge = ctrl[SPI_CTRL_RX_NEGEDGE];
  assign tx_negedge = ctrl[SPI_CTRL_TX_NEGEDGE];
  assign lsb        = ctrl[SPI_CTRL_LSB];

  // Automatic slave select only drives the lines while a transfer is running
  assign ss_pad_o = ~(ss & {SS_NB{ctrl[SPI_CTRL_ASS] ? tip : 1'b1}});

  // One-hot TX word load strobe, live only during the access cycle
  always_comb begin
    latch = 4'b0000;
    if (wr_ok && !wb_adr_i[4]) latch[wb_adr_i[3:2]] = 1'b1;
  end

  // Read data selection for the addressed word
  always_comb begin
    rd_data = 32'd0;
    case (word)
      SPI_RX_0:   rd_data = rx_view[31:0];
      SPI_RX_1:   rd_data = rx_view[63:32];
      SPI_RX_2:   rd_data = rx_view[95:64];
      SPI_RX_3:   rd_data = rx_view[127:96];
      SPI_CTRL:   rd_data = 32'(ctrl);
      SPI_DIVIDE: rd_data = 32'(divider);
      SPI_SS:     rd_data = 32'(ss);
      default:    rd_data = 32'd0;
    endcase
  end

  // CTRL register; the end-of-transfer clear of go overrides a coincident set
  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_n) begin
      ctrl <= '0;
    end else begin
      if (wr_ok && word == SPI_CTRL)
        ctrl <= (ctrl & ~ctrl_m) | (wb_dat_i[SPI_CTRL_W-1:0] & ctrl_m);
      if (xfer_end) ctrl[SPI_CTRL_GO] <= 1'b0;
    end
  end

  // Clock divider register with byte-lane writes
  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_n) begin
      divider <= '0;
    end else if (wr_ok && word == SPI_DIVIDE) begin
      divider <= (divider & ~lanes[DIV_WIDTH-1:0]) |
                 (wb_dat_i[DIV_WIDTH-1:0] & lanes[DIV_WIDTH-1:0]);
    end
  end

  // Slave-select register with byte-lane writes
  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_n) begin
      ss <= '0;
    end else if (wr_ok && word == SPI_SS) begin
      ss <= (ss & ~lanes[SS_NB-1:0]) | (wb_dat_i[SS_NB-1:0] & lanes[SS_NB-1:0]);
    end
  end

  // Registered bus response: one-cycle ack, or err for the unmapped word
  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_n) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      wb_ack_o <= access & (word != SPI_UNMAPPED);
      wb_err_o <= access & (word == SPI_UNMAPPED);
      if (access) wb_dat_o <= rd_data;
    end
  end

  // End-of-transfer interrupt; a new set beats the clear-on-access
  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_n) begin
      wb_int_o <= 1'b0;
    end else if (xfer_end && ctrl[SPI_CTRL_IE]) begin
      wb_int_o <= 1'b1;
    end else if (access) begin
      wb_int_o <= 1'b0;
    end
  end

endmodule
